fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised single-clock FIFO, the successor to the fixed 8x16 FIFO used across the fifo environment. Generalises data width and depth. Adds a programmable almost-full/almost-empty watermark, a live fill count, a synchronous flush, and sticky-free single-cycle error pulses. Sits between any producer/consumer pair on one clock domain and is driven by the existing fifo bench through an extended interface.

## Interface
- DATA_WIDTH, 8, width of each entry
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH (default 16)
- AFULL_THRESH, DEPTH-4 (12), almost_full asserts when count >= this; legal 1..DEPTH
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this; legal 0..DEPTH-1
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush, highest priority
- push  in  1  write request
- data_in  in  DATA_WIDTH  write data
- pop  in  1  read request
- data_out  out  DATA_WIDTH  read data
- count  out  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH
- full, empty  out  1  count==DEPTH / count==0
- almost_full, almost_empty  out  1  watermark flags
- push_err_on_full  out  1  one-cycle pulse: push rejected
- pop_err_on_empty  out  1  one-cycle pulse: pop rejected

## Operation
- Acceptance is decided on the status at the clock edge:
  - push is accepted iff !full.
  - pop is accepted iff !empty.
  - Both are evaluated independently, so there is no pass-through and no write-into-slot-being-freed.
- Full + push + pop: the pop is accepted and the push is rejected with push_err_on_full.
- Empty + push + pop: the push is accepted and the pop is rejected with pop_err_on_empty.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Accepted pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged when both or neither are accepted
  - never exceeds DEPTH and never underflows
- The flags are decoded from the registered count and the registered next value, so all flags are registered outputs.
- clear:
  - Pointers and count go to 0, the flags return to their reset values, and both error outputs are 0.
  - A push or pop in the same cycle is ignored and flags no error.
  - data_out holds its value.
- Reset values:
  - data_out 0, count 0
  - empty 1, almost_empty 1, full 0, almost_full 0
  - both error outputs 0
- Reset mid-operation discards all contents. Memory contents are not reset.

## Timing
- Status: count and all flags reflect an edge's push/pop at that same edge, so they are valid the cycle after the request.
- Error pulses assert for exactly one cycle, the cycle after the rejected request. Back-to-back rejected requests give a continuous high.
- Read latency without FWFT: data_out loads mem[rd_ptr] at the edge where the pop is accepted, so it is valid the cycle after pop. It holds until the next accepted pop.
- Write-to-read: an entry pushed at edge N is poppable at edge N+1 (empty deasserts after N).

## Configuration
- FIFO_FWFT_EN:
  - Defined: first-word-fall-through. data_out presents the head entry mem[rd_ptr] combinationally whenever !empty, and is forced to 0 when empty. An accepted pop advances to the next entry. Zero read latency.
  - Undefined: registered read as described under Timing.
- Acceptance rules, count, flags and error behaviour are identical in both builds.

## Structure
- Package fifo_pkg holds:
  - default constants FIFO_DATA_WIDTH_DEF=8 and FIFO_ADDR_WIDTH_DEF=4
  - a function computing the default AFULL_THRESH from ADDR_WIDTH
  - a parameter-legality check used by an elaboration-time assertion
- Sub-module fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one read port. The read port is combinational when FIFO_FWFT_EN is defined and registered otherwise.
- The top level owns the pointers, count, flags and errors.

## Test plan
Defaults DEPTH=16, AFULL=12, AEMPTY=4.
- Reset, then push 0x01..0x10 on 16 consecutive cycles -> count 16, full=1, almost_full from the 12th push, empty=0. A 17th push of 0xAA gives push_err_on_full=1 for one cycle, count stays 16, and 0xAA is never read.
- Pop 16 times after the fill -> data_out 0x01..0x10 in order (registered build: one cycle after each pop). empty=1 after the last pop. A 17th pop gives pop_err_on_empty pulse, and data_out holds 0x10.
- Wrap-around: push 10, pop 10, push 10 values 0x20..0x29 -> the pointers wrap, and the values read back in order with count tracking 10.
- Simultaneous push+pop:
  - at count 5 -> count stays 5 and order is preserved
  - at full -> pop accepted, push error, count 15
  - at empty -> push accepted, pop error, count 1
- Push 7 entries, then assert clear together with a push -> count 0, empty=1, no error pulse, and the next push/pop round-trip returns the new data.
- Assert rst_n low asynchronously mid-burst (count 9) -> all outputs go to their reset values immediately without a clock edge. Traffic resumes cleanly after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - default data/address widths
//   - the registered status flag bundle and its reset value
//   - the default almost-full threshold for a given address width
//   - the parameter legality check used at elaboration time
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH_DEF = 8;
   localparam int FIFO_ADDR_WIDTH_DEF = 4;

   // Registered status flags, grouped so they share one next-state decode.
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FIFO_FLAGS_RST = '{
      full:         1'b0,
      empty:        1'b1,
      almost_full:  1'b0,
      almost_empty: 1'b1
   };

   // Four entries of headroom below full; tiny FIFOs fall back to DEPTH.
   function automatic int fifo_afull_def(input int addr_width);
      int depth;
      depth = 1 << addr_width;
      return (depth > 4) ? depth - 4 : depth;
   endfunction

   function automatic bit fifo_params_legal(input int data_width,
                                            input int addr_width,
                                            input int afull_thresh,
                                            input int aempty_thresh);
      int depth;
      depth = 1 << addr_width;
      return (data_width >= 1) && (addr_width >= 1) && (addr_width <= 30) &&
             (afull_thresh >= 1) && (afull_thresh <= depth) &&
             (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_WIDTH register array, one synchronous write port and one
// read port.
//   Build option FIFO_FWFT_EN:
//     defined   -> read port is combinational (rd_data = mem[rd_addr])
//     undefined -> read port is registered, loading mem[rd_addr] when rd_en
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr       read strobe and address
//   rd_data             read data
// ---------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the storage array has no reset; every entry is written before it
   // can be read, and resetting it would turn the array into DEPTH*DATA_WIDTH
   // reset flops instead of plain storage.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

`ifdef FIFO_FWFT_EN
   assign rd_data = mem_q[rd_addr];

   // Reset and read strobe are only needed by the registered read port.
   logic unused_rd;
   assign unused_rd = &{1'b0, rst_n, rd_en};
`else
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with fill count, programmable watermarks,
// synchronous flush and single-cycle push/pop error pulses.
// Build option FIFO_FWFT_EN: first-word-fall-through read (data_out shows the
// head entry while not empty, 0 when empty); otherwise data_out is loaded at
// the edge that accepts a pop and holds until the next accepted pop.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 synchronous flush, overrides push/pop
//   push, data_in         write request and data
//   pop, data_out         read request and data
//   count                 stored entries, 0..DEPTH
//   full, empty           count==DEPTH / count==0
//   almost_full           count >= AFULL_THRESH
//   almost_empty          count <= AEMPTY_THRESH
//   push_err_on_full      one-cycle pulse after a rejected push
//   pop_err_on_empty      one-cycle pulse after a rejected pop
// ---------------------------------------------------------------------------
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = FIFO_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH_DEF,
   parameter int AFULL_THRESH  = fifo_afull_def(ADDR_WIDTH),
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  push_err_on_full,
   output logic                  pop_err_on_empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   localparam logic [CNT_W-1:0]      CNT_DEPTH  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]      CNT_AFULL  = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0]      CNT_AEMPTY = CNT_W'(AEMPTY_THRESH);
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   if (!fifo_params_legal(DATA_WIDTH, ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH))
   begin : g_bad_params
      $error("fifo_sync_param: illegal DATA_WIDTH/ADDR_WIDTH/threshold combination");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0]      count_d, count_q;
   fifo_flags_t           flags_d, flags_q;
   logic                  push_err_d, push_err_q;
   logic                  pop_err_d, pop_err_q;

   logic                  push_ok;
   logic                  pop_ok;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   // Acceptance looks only at the registered flags, so push and pop are
   // independent: a full FIFO never writes into the slot a pop is freeing.
   assign push_ok = push && !flags_q.full;
   assign pop_ok  = pop  && !flags_q.empty;

   // NOTE: every output of this block is given a default first so no path
   // leaves a value unassigned, which would infer a latch.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      push_err_d = 1'b0;
      pop_err_d  = 1'b0;

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         push_err_d = push && flags_q.full;
         pop_err_d  = pop  && flags_q.empty;
      end

      // Flags are decoded from the next count and registered, so they line up
      // with count. After a clear count_d is 0, which yields the reset flags.
      flags_d.full         = (count_d == CNT_DEPTH);
      flags_d.empty        = (count_d == '0);
      flags_d.almost_full  = (count_d >= CNT_AFULL);
      flags_d.almost_empty = (count_d <= CNT_AEMPTY);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; the combinational block above uses blocking ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         flags_q    <= FIFO_FLAGS_RST;
         push_err_q <= 1'b0;
         pop_err_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flags_q    <= flags_d;
         push_err_q <= push_err_d;
         pop_err_q  <= pop_err_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push_ok && !clear),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (pop_ok && !clear),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

`ifdef FIFO_FWFT_EN
   // Stale array contents are hidden while the FIFO is empty.
   assign data_out = flags_q.empty ? '0 : mem_rd_data;
`else
   assign data_out = mem_rd_data;
`endif

   assign count            = count_q;
   assign full             = flags_q.full;
   assign empty            = flags_q.empty;
   assign almost_full      = flags_q.almost_full;
   assign almost_empty     = flags_q.almost_empty;
   assign push_err_on_full = push_err_q;
   assign pop_err_on_empty = pop_err_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
// Scoreboard bench for fifo_sync_param at default parameters (DEPTH 16,
// almost_full at 12, almost_empty at 4). A queue-based reference model
// predicts every post-edge output; a monitor on the falling edge compares.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

   localparam int DW     = 8;
   localparam int AW     = 4;
   localparam int DEPTH  = 16;
   localparam int AFULL  = 12;
   localparam int AEMPTY = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear_i = 1'b0;
   logic          push_i = 1'b0;
   logic          pop_i = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] data_out;
   logic [AW:0]   count;
   logic          full, empty, almost_full, almost_empty;
   logic          push_err, pop_err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [DW-1:0] dout;
      int            cnt;
      logic          full;
      logic          empty;
      logic          afull;
      logic          aempty;
      logic          perr;
      logic          oerr;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_dout = '0;

   fifo_sync_param #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .AFULL_THRESH  (AFULL),
      .AEMPTY_THRESH (AEMPTY)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .clear            (clear_i),
      .push             (push_i),
      .data_in          (din),
      .pop              (pop_i),
      .data_out         (data_out),
      .count            (count),
      .full             (full),
      .empty            (empty),
      .almost_full      (almost_full),
      .almost_empty     (almost_empty),
      .push_err_on_full (push_err),
      .pop_err_on_empty (pop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of stored words. Decides acceptance from
   // the occupancy before the edge and records what the outputs must be after.
   always @(posedge clk) begin
      exp_t e;
      int   sz;
      e.perr = 1'b0;
      e.oerr = 1'b0;
      if (!rst_n) begin
         model_q.delete();
         model_dout = '0;
      end else begin
         sz = model_q.size();
         if (clear_i) begin
            model_q.delete();
         end else begin
            e.perr = push_i && (sz == DEPTH);
            e.oerr = pop_i && (sz == 0);
            if (pop_i && sz > 0) model_dout = model_q.pop_front();
            if (push_i && sz < DEPTH) model_q.push_back(din);
         end
      end
      sz = model_q.size();
`ifdef FIFO_FWFT_EN
      e.dout = (sz > 0) ? model_q[0] : '0;
`else
      e.dout = model_dout;
`endif
      e.cnt    = sz;
      e.full   = (sz == DEPTH);
      e.empty  = (sz == 0);
      e.afull  = (sz >= AFULL);
      e.aempty = (sz <= AEMPTY);
      exp_q.push_back(e);
   end

   // Monitor: consumes one prediction per clock, half a cycle after the edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("data_out", 32'(data_out), 32'(e.dout));
         check("count", 32'(count), 32'(e.cnt));
         check("full", 32'(full), 32'(e.full));
         check("empty", 32'(empty), 32'(e.empty));
         check("almost_full", 32'(almost_full), 32'(e.afull));
         check("almost_empty", 32'(almost_empty), 32'(e.aempty));
         check("push_err_on_full", 32'(push_err), 32'(e.perr));
         check("pop_err_on_empty", 32'(pop_err), 32'(e.oerr));
      end
   end

   // Applies one cycle of inputs at a falling edge and waits for the next one.
   task automatic drive(input logic p, input logic o, input logic c, input logic [DW-1:0] d);
      push_i  = p;
      pop_i   = o;
      clear_i = c;
      din     = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Fill to full, then one rejected push that must never be read.
      for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, 1'b0, DW'(i));
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      idle(2);

      // Drain in order, then one rejected pop; data_out holds the last word.
      for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, 1'b0, '0);
      idle(2);

      // Pointer wrap-around.
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, '0);
      idle(1);

      // Simultaneous push+pop at count 5.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, '0);

      // Simultaneous push+pop at full, then drain.
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
      drive(1'b1, 1'b1, 1'b0, 8'h5A);
      for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b0, '0);

      // Simultaneous push+pop at empty, then retrieve the accepted word.
      drive(1'b1, 1'b1, 1'b0, 8'hC3);
      drive(1'b0, 1'b1, 1'b0, '0);
      idle(1);

      // Flush with a coincident push, then a fresh round-trip.
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
      drive(1'b1, 1'b0, 1'b1, 8'h55);
      drive(1'b1, 1'b0, 1'b0, 8'h66);
      drive(1'b0, 1'b1, 1'b0, '0);
      idle(2);

      // Asynchronous reset in the middle of a burst at count 9.
      for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
      push_i = 1'b1;
      din    = 8'hEE;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst data_out", 32'(data_out), 32'h0);
      check("async_rst count", 32'(count), 32'h0);
      check("async_rst empty", 32'(empty), 32'h1);
      check("async_rst almost_empty", 32'(almost_empty), 32'h1);
      check("async_rst full", 32'(full), 32'h0);
      check("async_rst almost_full", 32'(almost_full), 32'h0);
      check("async_rst push_err", 32'(push_err), 32'h0);
      check("async_rst pop_err", 32'(pop_err), 32'h0);
      push_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, DW'(8'h70 + i));
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0);

      // Randomised traffic: a fill-leaning phase then a drain-leaning phase,
      // with occasional flushes.
      for (int i = 0; i < 600; i++) begin
         logic p, o, c;
         if (i < 300) begin
            p = ($urandom_range(3, 0) != 0);
            o = ($urandom_range(1, 0) != 0);
         end else begin
            p = ($urandom_range(1, 0) != 0);
            o = ($urandom_range(3, 0) != 0);
         end
         c = ($urandom_range(39, 0) == 0);
         drive(p, o, c, DW'($urandom));
      end
      idle(3);

      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
